// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit MIPS execute stage: opcodes, ALU commands
// and the layout of the decoded issue bundle.
package mips_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_SLTI  = 4'b0010;
    localparam logic [3:0] OP_ANDI  = 4'b0011;
    localparam logic [3:0] OP_ORI   = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b0101;
    localparam logic [3:0] OP_SLLI  = 4'b0110;
    localparam logic [3:0] OP_SRLI  = 4'b0111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_EQ  = 3'b111;

    localparam int BUNDLE_W = 42;

    // Two spare bits pad the bundle to 42; they are always written as zero.
    typedef struct packed {
        logic [1:0]  spare;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [2:0]  cmd;
        logic [2:0]  dest;
        logic        wr_en;
        logic        illegal;
    } issue_bundle_t;

endpackage

// File: rtl/issue_fifo2.sv
// Generic 2-entry valid/ready FIFO with synchronous flush. in_ready depends only
// on the stored count, so no combinational path exists from out_ready.
module issue_fifo2 #(
    parameter int DATA_W = 42
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic [1:0]        count_p1;
    logic              wr_ptr_p1;
    logic              rd_ptr_p1;
    logic [DATA_W-1:0] mem_p1 [2];
    logic              push;
    logic              pop;

    assign in_ready  = (count_p1 != 2'd2);
    assign out_valid = (count_p1 != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // ---- stage p1: occupancy and pointers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_p1  <= 2'd0;
            wr_ptr_p1 <= 1'b0;
            rd_ptr_p1 <= 1'b0;
        end else if (flush) begin
            count_p1  <= 2'd0;
            wr_ptr_p1 <= 1'b0;
            rd_ptr_p1 <= 1'b0;
        end else begin
            if (push) wr_ptr_p1 <= ~wr_ptr_p1;
            if (pop)  rd_ptr_p1 <= ~rd_ptr_p1;
            case ({push, pop})
                2'b10:   count_p1 <= count_p1 + 2'd1;
                2'b01:   count_p1 <= count_p1 - 2'd1;
                default: count_p1 <= count_p1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_p1[wr_ptr_p1] <= in_data;
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign out_data = out_valid ? mem_p1[rd_ptr_p1] : '0;

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue register: decodes INSTR, selects operands and queues the
// bundle for the ALU. Define ALU_ISSUE_FWD_EN to enable the forwarding mux.
import mips_pkg::*;

module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] INSTR,
    input  logic [15:0] RS_DATA,
    input  logic [15:0] RT_DATA,
    input  logic        fwd_valid,
    input  logic [2:0]  fwd_rd,
    input  logic [15:0] fwd_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] OP1,
    output logic [15:0] OP2,
    output logic [2:0]  cmd,
    output logic [2:0]  dest,
    output logic        wr_en,
    output logic        illegal
);

    logic [3:0]         op_p0;
    logic [2:0]         rs_idx_p0;
    logic [2:0]         rt_idx_p0;
    logic [2:0]         rd_idx_p0;
    logic [2:0]         funct_p0;
    logic signed [5:0]  imm6_p0;
    logic signed [15:0] imm_sext_p0;
    logic [15:0]        imm_zext_p0;
    logic [15:0]        shamt_p0;
    logic [15:0]        rs_val_p0;
    logic [15:0]        rt_val_p0;
    issue_bundle_t      bundle_p0;
    issue_bundle_t      bundle_p1;
    logic [BUNDLE_W-1:0] head_p1;
    logic [1:0]         unused_spare;

    assign op_p0       = INSTR[15:12];
    assign rs_idx_p0   = INSTR[11:9];
    assign rt_idx_p0   = INSTR[8:6];
    assign rd_idx_p0   = INSTR[5:3];
    assign funct_p0    = INSTR[2:0];
    assign imm6_p0     = $signed(INSTR[5:0]);
    assign imm_sext_p0 = 16'(imm6_p0);
    assign imm_zext_p0 = {10'd0, INSTR[5:0]};
    assign shamt_p0    = {12'd0, INSTR[3:0]};

`ifdef ALU_ISSUE_FWD_EN
    function automatic logic [15:0] sel_operand(input logic [2:0]  idx,
                                                input logic [15:0] rf_data,
                                                input logic        f_vld,
                                                input logic [2:0]  f_rd,
                                                input logic [15:0] f_data);
        if (idx == 3'd0) return 16'h0000;
        if (f_vld && (f_rd == idx)) return f_data;
        return rf_data;
    endfunction

    assign rs_val_p0 = sel_operand(rs_idx_p0, RS_DATA, fwd_valid, fwd_rd, fwd_data);
    assign rt_val_p0 = sel_operand(rt_idx_p0, RT_DATA, fwd_valid, fwd_rd, fwd_data);
`else
    function automatic logic [15:0] sel_operand(input logic [2:0]  idx,
                                                input logic [15:0] rf_data);
        return (idx == 3'd0) ? 16'h0000 : rf_data;
    endfunction

    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data};
    assign rs_val_p0  = sel_operand(rs_idx_p0, RS_DATA);
    assign rt_val_p0  = sel_operand(rt_idx_p0, RT_DATA);
`endif

    // ---- stage p0: decode in the accept cycle ----
    always_comb begin
        bundle_p0       = '0;
        bundle_p0.op1   = rs_val_p0;
        bundle_p0.dest  = rt_idx_p0;
        bundle_p0.wr_en = 1'b1;
        case (op_p0)
            OP_RTYPE: begin
                bundle_p0.cmd  = funct_p0;
                bundle_p0.op2  = rt_val_p0;
                bundle_p0.dest = rd_idx_p0;
            end
            OP_ADDI: begin
                bundle_p0.cmd = ALU_ADD;
                bundle_p0.op2 = $unsigned(imm_sext_p0);
            end
            OP_SLTI: begin
                bundle_p0.cmd = ALU_SLT;
                bundle_p0.op2 = $unsigned(imm_sext_p0);
            end
            OP_ANDI: begin
                bundle_p0.cmd = ALU_AND;
                bundle_p0.op2 = imm_zext_p0;
            end
            OP_ORI: begin
                bundle_p0.cmd = ALU_OR;
                bundle_p0.op2 = imm_zext_p0;
            end
            OP_BEQ: begin
                // Branch compare produces no register result.
                bundle_p0.cmd   = ALU_EQ;
                bundle_p0.op2   = rt_val_p0;
                bundle_p0.dest  = 3'd0;
                bundle_p0.wr_en = 1'b0;
            end
            OP_SLLI: begin
                bundle_p0.cmd = ALU_SLL;
                bundle_p0.op2 = shamt_p0;
            end
            OP_SRLI: begin
                bundle_p0.cmd = ALU_SRL;
                bundle_p0.op2 = shamt_p0;
            end
            default: begin
                bundle_p0.cmd     = ALU_ADD;
                bundle_p0.dest    = 3'd0;
                bundle_p0.wr_en   = 1'b0;
                bundle_p0.illegal = 1'b1;
            end
        endcase
    end

    // ---- stage p1: two-entry decoupling buffer ----
    issue_fifo2 #(
        .DATA_W (BUNDLE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (bundle_p0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_p1)
    );

    assign bundle_p1    = issue_bundle_t'(head_p1);
    assign unused_spare = bundle_p1.spare;
    assign OP1          = bundle_p1.op1;
    assign OP2          = bundle_p1.op2;
    assign cmd          = bundle_p1.cmd;
    assign dest         = bundle_p1.dest;
    assign wr_en        = bundle_p1.wr_en;
    assign illegal      = bundle_p1.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: stimulus pushes hand-computed bundles, a
// negedge monitor pops and compares on every out_valid && out_ready transfer.
`timescale 1ns/1ps
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] INSTR = 16'h0000;
    logic [15:0] RS_DATA = 16'h0000;
    logic [15:0] RT_DATA = 16'h0000;
    logic        fwd_valid = 1'b0;
    logic [2:0]  fwd_rd = 3'd0;
    logic [15:0] fwd_data = 16'h0000;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] OP1, OP2;
    logic [2:0]  cmd, dest;
    logic        wr_en, illegal;

`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] op1;
        logic [15:0] op2;
        logic [2:0]  cmd;
        logic [2:0]  dest;
        logic        wr_en;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    alu_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .INSTR     (INSTR),
        .RS_DATA   (RS_DATA),
        .RT_DATA   (RT_DATA),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .OP1       (OP1),
        .OP2       (OP2),
        .cmd       (cmd),
        .dest      (dest),
        .wr_en     (wr_en),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] op1, input logic [15:0] op2,
                                input logic [2:0] c, input logic [2:0] d,
                                input logic w, input logic ill);
        exp_t e;
        e.op1 = op1; e.op2 = op2; e.cmd = c; e.dest = d; e.wr_en = w; e.illegal = ill;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [15:0] instr, input logic [15:0] rs,
                         input logic [15:0] rt, input exp_t e);
        bit acc = 1'b0;
        INSTR = instr; RS_DATA = rs; RT_DATA = rt; in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                sb.push_back(e);
                break;
            end
        end
        if (!acc) chk("issue_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        #1 chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("issue_out", {OP1, OP2, cmd, dest, wr_en, illegal}, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 chk("reset_state", {out_valid, in_ready, OP1, OP2, cmd, dest, wr_en, illegal},
               {1'b0, 1'b1, 40'h0});
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // R-type ADD, then one-cycle latency into an empty buffer
        issue(16'h0298, 16'h0005, 16'h0007, mk(16'h0005, 16'h0007, 3'b000, 3'd3, 1'b1, 1'b0));
        @(negedge clk) chk("add_latency", out_valid, 1'b1);
        @(posedge clk); #1;

        // Back-to-back decode coverage
        issue(16'h153E, 16'h0010, 16'h0000, mk(16'h0010, 16'hFFFE, 3'b000, 3'd4, 1'b1, 1'b0));
        issue(16'h353E, 16'h0010, 16'h0000, mk(16'h0010, 16'h003E, 3'b101, 3'd4, 1'b1, 1'b0));
        issue(16'h0171, 16'hAAAA, 16'h0033, mk(16'h0000, 16'h0033, 3'b001, 3'd6, 1'b1, 1'b0));
        issue(16'h5640, 16'h1111, 16'h2222, mk(16'h1111, 16'h2222, 3'b111, 3'd0, 1'b0, 1'b0));
        issue(16'h2260, 16'h0007, 16'h0000, mk(16'h0007, 16'hFFE0, 3'b011, 3'd1, 1'b1, 1'b0));
        issue(16'h48AA, 16'h0100, 16'h0000, mk(16'h0100, 16'h002A, 3'b110, 3'd2, 1'b1, 1'b0));
        issue(16'hF698, 16'h9999, 16'h5555, mk(16'h9999, 16'h0000, 3'b000, 3'd0, 1'b0, 1'b1));
        drain();

        // Forwarding
        fwd_valid = 1'b1; fwd_rd = 3'd1; fwd_data = 16'h1234;
        issue(16'h0298, 16'h0005, 16'h0007,
              mk(FWD ? 16'h1234 : 16'h0005, 16'h0007, 3'b000, 3'd3, 1'b1, 1'b0));
        fwd_rd = 3'd0;
        issue(16'h0098, 16'h0005, 16'h0007, mk(16'h0000, 16'h0007, 3'b000, 3'd3, 1'b1, 1'b0));
        fwd_rd = 3'd2;
        issue(16'h0298, 16'h0005, 16'h0007,
              mk(16'h0005, FWD ? 16'h1234 : 16'h0007, 3'b000, 3'd3, 1'b1, 1'b0));
        fwd_valid = 1'b0; fwd_rd = 3'd1;
        issue(16'h0298, 16'h0005, 16'h0007, mk(16'h0005, 16'h0007, 3'b000, 3'd3, 1'b1, 1'b0));
        drain();

        // Back-pressure: two accepts fill the buffer, third waits
        out_ready = 1'b0;
        issue(16'h62B5, 16'h00F0, 16'h0000, mk(16'h00F0, 16'h0005, 3'b010, 3'd2, 1'b1, 1'b0));
        issue(16'h7ECC, 16'h8000, 16'h0000, mk(16'h8000, 16'h000C, 3'b100, 3'd3, 1'b1, 1'b0));
        fork
            issue(16'h48AA, 16'h0100, 16'h0000, mk(16'h0100, 16'h002A, 3'b110, 3'd2, 1'b1, 1'b0));
            begin
                @(negedge clk);
                chk("bp_in_ready_full", in_ready, 1'b0);
                chk("bp_out_valid_held", out_valid, 1'b1);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // Flush with two entries held and a same-cycle input
        out_ready = 1'b0;
        issue(16'h0298, 16'h0005, 16'h0007, mk(16'h0005, 16'h0007, 3'b000, 3'd3, 1'b1, 1'b0));
        issue(16'h153E, 16'h0010, 16'h0000, mk(16'h0010, 16'hFFFE, 3'b000, 3'd4, 1'b1, 1'b0));
        flush = 1'b1; INSTR = 16'h48AA; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("flush_input_dropped", out_valid, 1'b0);
        @(posedge clk); #1;
        issue(16'h0171, 16'hAAAA, 16'h0033, mk(16'h0000, 16'h0033, 3'b001, 3'd6, 1'b1, 1'b0));
        drain();

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        issue(16'h0298, 16'h0005, 16'h0007, mk(16'h0005, 16'h0007, 3'b000, 3'd3, 1'b1, 1'b0));
        issue(16'h62B5, 16'h00F0, 16'h0000, mk(16'h00F0, 16'h0005, 3'b010, 3'd2, 1'b1, 1'b0));
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {out_valid, in_ready, OP1, OP2, cmd, dest, wr_en, illegal},
               {1'b0, 1'b1, 40'h0});
        sb.delete();
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 out_ready = 1'b1;
        issue(16'hF698, 16'h9999, 16'h5555, mk(16'h9999, 16'h0000, 3'b000, 3'd0, 1'b0, 1'b1));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
